// File: rtl/ddc_quad_mixer_decim.sv
// rtl/ddc_quad_mixer_decim.sv - quadrature mixer with accumulate-and-dump decimator
// Three-stage pipe: multiply, integrate/dump, round-shift-saturate.
module ddc_quad_mixer_decim #(
  parameter int DATA_WIDTH    = 16,
  parameter int NCO_WIDTH     = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int ACC_WIDTH     = 40,
  parameter int RATIO_WIDTH   = 8,
  parameter int DEFAULT_SHIFT = 15
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [DATA_WIDTH-1:0]  adc_data,
  input  logic                   adc_valid,
  input  logic [NCO_WIDTH-1:0]   nco_sin,
  input  logic [NCO_WIDTH-1:0]   nco_cos,
  input  logic [RATIO_WIDTH-1:0] cfg_ratio,
  input  logic [5:0]             cfg_shift,
  input  logic                   cfg_load,
  output logic                   cfg_busy,
  output logic [OUT_WIDTH-1:0]   i_out,
  output logic [OUT_WIDTH-1:0]   q_out,
  output logic                   out_valid,
  output logic                   sat_flag,
  input  logic                   sat_clr
);

  localparam int PW = DATA_WIDTH + NCO_WIDTH;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] xExt, cosExt, sinExt, prodCos, prodSin;
  logic signed [PW-1:0] pI, pQ;
  logic                 s1Valid;

  logic signed [ACC_WIDTH-1:0] accI, accQ, sumI, sumQ, dumpI, dumpQ;
  logic [RATIO_WIDTH-1:0]      cnt, activeRatio, shadowRatio;
  logic [5:0]                  activeShift, shadowShift, dumpShift;
  logic                        dumpValid, busy, blockEnd, applyCfg;

  logic [5:0]           shEff;
  logic [RW-1:0]        roundAdd;
  logic signed [RW-1:0] rndI, rndQ, shI, shQ;
  logic                 satHiI, satLoI, satHiQ, satLoQ;
  logic [OUT_WIDTH-1:0] nextI, nextQ;

  always_comb begin
    xExt    = {{NCO_WIDTH{adc_data[DATA_WIDTH-1]}}, adc_data};
    cosExt  = {{DATA_WIDTH{nco_cos[NCO_WIDTH-1]}}, nco_cos};
    sinExt  = {{DATA_WIDTH{nco_sin[NCO_WIDTH-1]}}, nco_sin};
    prodCos = xExt * cosExt;
    prodSin = xExt * sinExt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1Valid <= 1'b0;
      pI      <= '0;
      pQ      <= '0;
    end else begin
      s1Valid <= adc_valid;
      if (adc_valid) begin
        pI <= prodCos;
        pQ <= -prodSin;
      end
    end
  end

  // Shadow config only lands between blocks, so a block never mixes two ratios or shifts.
  always_comb begin
    sumI     = accI + {{(ACC_WIDTH-PW){pI[PW-1]}}, pI};
    sumQ     = accQ + {{(ACC_WIDTH-PW){pQ[PW-1]}}, pQ};
    blockEnd = s1Valid && (cnt == activeRatio);
    applyCfg = busy && !cfg_load && (cnt == '0) && !s1Valid;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      accI        <= '0;
      accQ        <= '0;
      cnt         <= '0;
      dumpValid   <= 1'b0;
      dumpI       <= '0;
      dumpQ       <= '0;
      dumpShift   <= 6'(DEFAULT_SHIFT);
      activeRatio <= '0;
      activeShift <= 6'(DEFAULT_SHIFT);
      shadowRatio <= '0;
      shadowShift <= 6'(DEFAULT_SHIFT);
      busy        <= 1'b0;
    end else begin
      dumpValid <= blockEnd;
      if (s1Valid) begin
        if (blockEnd) begin
          dumpI     <= sumI;
          dumpQ     <= sumQ;
          dumpShift <= activeShift;
          accI      <= '0;
          accQ      <= '0;
          cnt       <= '0;
        end else begin
          accI <= sumI;
          accQ <= sumQ;
          cnt  <= cnt + RATIO_WIDTH'(1);
        end
      end
      if (cfg_load) begin
        shadowRatio <= cfg_ratio;
        shadowShift <= cfg_shift;
        busy        <= 1'b1;
      end else if (applyCfg) begin
        activeRatio <= shadowRatio;
        activeShift <= shadowShift;
        busy        <= 1'b0;
      end
    end
  end

  assign cfg_busy = busy;

  // One extra bit keeps the rounding add from wrapping at the largest dump values.
  always_comb begin
    shEff    = ({26'd0, dumpShift} >= 32'(ACC_WIDTH)) ? 6'(ACC_WIDTH - 1) : dumpShift;
    roundAdd = (shEff != 6'd0) ? (RW'(1) << (shEff - 6'd1)) : '0;
    rndI     = $signed({dumpI[ACC_WIDTH-1], dumpI}) + $signed(roundAdd);
    rndQ     = $signed({dumpQ[ACC_WIDTH-1], dumpQ}) + $signed(roundAdd);
    shI      = rndI >>> shEff;
    shQ      = rndQ >>> shEff;
    satHiI   = shI > MAXV;
    satLoI   = shI < MINV;
    satHiQ   = shQ > MAXV;
    satLoQ   = shQ < MINV;
    nextI    = satHiI ? OUT_MAX : (satLoI ? OUT_MIN : shI[OUT_WIDTH-1:0]);
    nextQ    = satHiQ ? OUT_MAX : (satLoQ ? OUT_MIN : shQ[OUT_WIDTH-1:0]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= dumpValid;
      if (dumpValid) begin
        i_out <= nextI;
        q_out <= nextQ;
      end
      if (dumpValid && (satHiI || satLoI || satHiQ || satLoQ)) begin
        sat_flag <= 1'b1;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule
